// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch run/stop/clear sequencer.
package stopwatch_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STOP  = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    // Counter width needed to hold 0..div-1 (div >= 2).
    function automatic int unsigned cnt_width(input int unsigned div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/stopwatch_tick_gen.sv
// Base tick prescaler: counts enabled cycles 0..DIV-1 and emits a registered
// one-cycle tick on the cycle after the count reaches DIV-1.
module stopwatch_tick_gen
    import stopwatch_pkg::*;
#(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int unsigned            CNT_W    = cnt_width(DIV);
    localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic             w_last;

    assign w_last = (r_cnt == CNT_LAST);

    // Prescaler and tick register: clear wins, count only when enabled, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (i_clr) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (i_en) begin
            r_tick <= w_last;
            r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/stop/clear sequencer: turns debounced button pulses into a
// gated base tick and a one-cycle clear for the counter chain.
// Optional lap hold register enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TICK_HZ = 100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_btn_run,
    input  logic               i_btn_clear,
    input  logic               i_btn_lap,
    output logic               o_tick,
    output logic               o_clear,
    output logic               o_running,
    output logic               o_lap_hold,
    output logic [STATE_W-1:0] o_state
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;

    state_t r_state;
    state_t w_next;
    logic   w_tick_en;
    logic   w_tick_clr;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; in STOP a simultaneous clear beats run.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (i_btn_run) begin
                    w_next = ST_RUN;
                end else if (i_btn_clear) begin
                    w_next = ST_CLEAR;
                end
            end
            ST_RUN: begin
                if (i_btn_run) begin
                    w_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (i_btn_clear) begin
                    w_next = ST_CLEAR;
                end else if (i_btn_run) begin
                    w_next = ST_RUN;
                end
            end
            ST_CLEAR: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Moore output decode from the state register.
    always_comb begin
        o_running  = (r_state == ST_RUN);
        o_clear    = (r_state == ST_CLEAR);
        o_state    = r_state;
        w_tick_en  = (r_state == ST_RUN);
        w_tick_clr = (r_state == ST_IDLE) || (r_state == ST_CLEAR);
    end

    stopwatch_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_tick_en),
        .i_clr  (w_tick_clr),
        .o_tick (o_tick)
    );

`ifdef STOPWATCH_LAP_EN
    logic r_lap_hold;

    // Lap hold: toggled by lap in RUN, dropped on the edge that enters CLEAR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lap_hold <= 1'b0;
        end else if (w_next == ST_CLEAR) begin
            r_lap_hold <= 1'b0;
        end else if ((r_state == ST_RUN) && i_btn_lap) begin
            r_lap_hold <= ~r_lap_hold;
        end
    end

    assign o_lap_hold = r_lap_hold;
`else
    logic w_unused_lap;

    assign w_unused_lap = i_btn_lap;
    assign o_lap_hold   = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl (CLK_HZ=1000, TICK_HZ=100 -> DIV=10).
module tb_stopwatch_ctrl;

    localparam int unsigned DIV = 10;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       i_btn_run;
    logic       i_btn_clear;
    logic       i_btn_lap;
    logic       o_tick;
    logic       o_clear;
    logic       o_running;
    logic       o_lap_hold;
    logic [1:0] o_state;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode numbers are the externally visible state codes,
    // run_cycles counts cycles spent running since the last clear/idle.
    logic [1:0] m_mode;
    int         m_run_cycles;
    logic       m_tick;
    logic       m_lap;

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .CLK_HZ  (1000),
        .TICK_HZ (100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_btn_run   (i_btn_run),
        .i_btn_clear (i_btn_clear),
        .i_btn_lap   (i_btn_lap),
        .o_tick      (o_tick),
        .o_clear     (o_clear),
        .o_running   (o_running),
        .o_lap_hold  (o_lap_hold),
        .o_state     (o_state)
    );

    function automatic logic [1:0] next_mode(input logic [1:0] mode, input logic run, input logic clr);
        case (mode)
            2'd0:    return run ? 2'd1 : (clr ? 2'd3 : 2'd0);
            2'd1:    return run ? 2'd2 : 2'd1;
            2'd2:    return clr ? 2'd3 : (run ? 2'd1 : 2'd2);
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [5:0] exp_vec();
        return {m_mode, (m_mode == 2'd1), (m_mode == 2'd3), m_tick, m_lap};
    endfunction

    function automatic logic [5:0] obs_vec();
        return {o_state, o_running, o_clear, o_tick, o_lap_hold};
    endfunction

    task automatic model_reset();
        m_mode       = 2'd0;
        m_run_cycles = 0;
        m_tick       = 1'b0;
        m_lap        = 1'b0;
    endtask

    // Every DIV-th cycle spent running yields a tick on the following cycle.
    task automatic model_edge(input logic run, input logic clr, input logic lap);
        logic [1:0] nm;
        nm     = next_mode(m_mode, run, clr);
        m_tick = (m_mode == 2'd1) && (((m_run_cycles + 1) % DIV) == 0);
        if (m_mode == 2'd1)
            m_run_cycles = m_run_cycles + 1;
        else if (m_mode == 2'd0 || m_mode == 2'd3)
            m_run_cycles = 0;
        if (LAP_EN) begin
            if (nm == 2'd3)
                m_lap = 1'b0;
            else if (m_mode == 2'd1 && lap)
                m_lap = ~m_lap;
        end
        m_mode = nm;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic run, input logic clr, input logic lap);
        i_btn_run   = run;
        i_btn_clear = clr;
        i_btn_lap   = lap;
        @(posedge clk);
        model_edge(run, clr, lap);
        @(negedge clk);
        i_btn_run   = 1'b0;
        i_btn_clear = 1'b0;
        i_btn_lap   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_btn_run = 1'b0; i_btn_clear = 1'b0; i_btn_lap = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_btn_run = 1'b0; i_btn_clear = 1'b0; i_btn_lap = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (obs_vec() !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected %b", obs_vec(), 6'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_idle: got %b expected %b", obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_run_cadence();
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (o_running !== 1'b1) begin
            n_fail++;
            $display("FAIL running_cycle1: got %b expected 1", o_running);
        end
        for (int c = 2; c <= 35; c++) begin
            step(1'b0, 1'b0, 1'b0);
            n_tests++;
            if (o_tick !== ((c == 11) || (c == 21) || (c == 31))) begin
                n_fail++;
                $display("FAIL cadence_c%0d: got tick %b expected %b", c, o_tick, (c == 11) || (c == 21) || (c == 31));
            end
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL cadence_model_c%0d: got %b expected %b", c, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_stop_resume();
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 30 && (m_run_cycles % DIV) != 4; i++)
            step(1'b0, 1'b0, 1'b0);
        n_tests++;
        if ((m_run_cycles % DIV) != 4 || o_running !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_setup: got running %b expected 1 at phase 4", o_running);
        end
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            n_tests++;
            if (o_tick !== 1'b0 || o_state !== 2'd2) begin
                n_fail++;
                $display("FAIL stopped_%0d: got tick %b state %0d expected 0 2", i, o_tick, o_state);
            end
            step(1'b0, 1'b0, 1'b0);
        end
        for (int k = 1; k <= 8; k++) begin
            step(k == 1, 1'b0, 1'b0);
            n_tests++;
            if (o_tick !== (k == 6)) begin
                n_fail++;
                $display("FAIL resume_k%0d: got tick %b expected %b", k, o_tick, k == 6);
            end
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL resume_model_k%0d: got %b expected %b", k, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_stop_clear_prio();
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        n_tests++;
        if ({o_state, o_clear, o_running} !== {2'd3, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL prio_clear: got state %0d clear %b running %b expected 3 1 0", o_state, o_clear, o_running);
        end
        step(1'b0, 1'b0, 1'b0);
        n_tests++;
        if ({o_state, o_clear, o_running} !== {2'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL prio_idle: got state %0d clear %b running %b expected 0 0 0", o_state, o_clear, o_running);
        end
    endtask

    task automatic test_clear_in_run();
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        for (int c = 2; c <= 25; c++) begin
            step(1'b0, (c == 5) || (c == 13) || (c == 20), 1'b0);
            n_tests++;
            if (o_clear !== 1'b0 || o_tick !== ((c == 11) || (c == 21))) begin
                n_fail++;
                $display("FAIL clear_in_run_c%0d: got clear %b tick %b expected 0 %b", c, o_clear, o_tick, (c == 11) || (c == 21));
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 30 && (m_run_cycles % DIV) != (DIV - 1); i++)
            step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        n_tests++;
        if ({o_tick, o_state} !== {1'b1, 2'd2}) begin
            n_fail++;
            $display("FAIL stop_on_tick: got tick %b state %0d expected 1 2", o_tick, o_state);
        end
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b0, 1'b0);
            n_tests++;
            if (o_tick !== 1'b0) begin
                n_fail++;
                $display("FAIL after_stop_tick_%0d: got %b expected 0", i, o_tick);
            end
        end
        // Resume from wrapped phase 0: a full DIV+1 cycles to the next tick.
        for (int k = 1; k <= 12; k++) begin
            step(k == 1, 1'b0, 1'b0);
            n_tests++;
            if (o_tick !== (k == DIV + 1)) begin
                n_fail++;
                $display("FAIL wrap_resume_k%0d: got %b expected %b", k, o_tick, k == DIV + 1);
            end
        end
    endtask

    task automatic test_lap();
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        n_tests++;
        if (o_lap_hold !== LAP_EN) begin
            n_fail++;
            $display("FAIL lap_on: got %b expected %b", o_lap_hold, LAP_EN);
        end
        for (int i = 0; i < 14; i++) begin
            step(1'b0, 1'b0, 1'b0);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL lap_ticks_%0d: got %b expected %b", i, obs_vec(), exp_vec());
            end
        end
        step(1'b0, 1'b0, 1'b1);
        n_tests++;
        if (o_lap_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL lap_off: got %b expected 0", o_lap_hold);
        end
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        n_tests++;
        if ({o_state, o_lap_hold} !== {2'd2, LAP_EN}) begin
            n_fail++;
            $display("FAIL lap_keep_stop: got state %0d hold %b expected 2 %b", o_state, o_lap_hold, LAP_EN);
        end
        step(1'b0, 1'b1, 1'b0);
        n_tests++;
        if ({o_state, o_lap_hold} !== {2'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL lap_clear: got state %0d hold %b expected 3 0", o_state, o_lap_hold);
        end
    endtask

    task automatic test_rst_mid_run();
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        n_tests++;
        if (obs_vec() !== 6'b0) begin
            n_fail++;
            $display("FAIL rst_mid_run: got %b expected %b", obs_vec(), 6'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step(1'b0, 1'b0, 1'b0);
            n_tests++;
            if (o_tick !== 1'b0 || obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL post_rst_%0d: got %b expected %b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b1;
                #1;
                model_reset();
                n_tests++;
                if (obs_vec() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL rand_rst_%0d: got %b expected %b", i, obs_vec(), exp_vec());
                end
                @(negedge clk);
                rst = 1'b0;
            end else begin
                step($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
                n_tests++;
                if (obs_vec() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL rand_%0d: got %b expected %b", i, obs_vec(), exp_vec());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_run_cadence();
        test_stop_resume();
        test_stop_clear_prio();
        test_clear_in_run();
        test_back_to_back();
        test_lap();
        test_rst_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
